// File: rtl/rggen_bridge_pkg.sv
// Shared types, response codes and strobe expansion for the AXI4-Lite host bridge.
package rggen_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWriteAccess,
        StReadAccess,
        StWriteResponse,
        StReadResponse
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Each strobe bit covers one byte lane; the result is sized for the widest
    // supported bus and the caller truncates to its own data width.
    function automatic logic [63:0] expand_strobe(input logic [7:0] strb,
                                                  input int unsigned data_width);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(data_width)) begin
                mask[i] = strb[i / 8];
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/rggen_axi4lite_host_bridge_if.sv
// AXI4-Lite channel bundle between the interconnect (master) and the bridge (slave).
interface rggen_axi4lite_host_bridge_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rggen_access_watchdog.sv
// Access timeout counter: cleared when an access starts, counts while enabled,
// flags expiry on the last permitted cycle. Fully tied off when TIMEOUT_CYCLES is 0.
module rggen_access_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
        logic w_unused;
        assign w_unused = ^{clk, rst_n, i_clear, i_enable};
        assign o_expire = 1'b0;
    end else begin : g_enabled
        localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        logic [CW-1:0] r_count;

        assign o_expire = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

        // Count access cycles; hold at the limit so expiry stays a single decision point
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count <= '0;
            end else if (i_clear) begin
                r_count <= '0;
            end else if (i_enable && !o_expire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rggen_axi4lite_host_bridge.sv
// AXI4-Lite slave that serialises reads and writes into single register-bus accesses.
module rggen_axi4lite_host_bridge
    import rggen_bridge_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rggen_axi4lite_host_bridge_if.slave axi,
    output logic                      o_req_valid,
    output logic                      o_req_write,
    output logic [ADDRESS_WIDTH-1:0]  o_req_address,
    output logic [DATA_WIDTH-1:0]     o_req_write_data,
    output logic [DATA_WIDTH-1:0]     o_req_write_mask,
    input  logic                      i_resp_valid,
    input  logic [1:0]                i_resp_status,
    input  logic [DATA_WIDTH-1:0]     i_resp_read_data
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);

    bridge_state_e r_state;
    bridge_state_e w_state_next;
    logic          r_priority_write;
    logic          r_write;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [DATA_WIDTH-1:0]    r_write_mask;
    logic [1:0]               r_status;
    logic [DATA_WIDTH-1:0]    r_read_data;

    logic w_idle;
    logic w_write_eligible;
    logic w_read_eligible;
    logic w_grant_write;
    logic w_grant_read;
    logic w_in_access;
    logic w_expire;
    logic w_access_done;
    logic w_resp_done;
    logic [DATA_WIDTH-1:0] w_mask;

    // Readies are combinational from IDLE and forced low while reset is held
    always_comb begin
        w_idle           = (r_state == StIdle) && rst_n;
        w_write_eligible = axi.awvalid && axi.wvalid;
        w_read_eligible  = axi.arvalid;
        w_grant_write    = w_idle && w_write_eligible && (r_priority_write || !w_read_eligible);
        w_grant_read     = w_idle && w_read_eligible && (!r_priority_write || !w_write_eligible);
        w_in_access      = (r_state == StWriteAccess) || (r_state == StReadAccess);
        w_access_done    = w_in_access && (i_resp_valid || w_expire);
        w_resp_done      = ((r_state == StWriteResponse) && axi.bready) ||
                           ((r_state == StReadResponse) && axi.rready);
        w_mask           = DATA_WIDTH'(expand_strobe(8'(axi.wstrb), DATA_WIDTH));
    end

    assign axi.awready      = w_grant_write;
    assign axi.wready       = w_grant_write;
    assign axi.arready      = w_grant_read;
    assign axi.bvalid       = (r_state == StWriteResponse);
    assign axi.bresp        = r_status;
    assign axi.rvalid       = (r_state == StReadResponse);
    assign axi.rresp        = r_status;
    assign axi.rdata        = r_read_data;
    assign o_req_valid      = w_in_access;
    assign o_req_write      = r_write;
    assign o_req_address    = r_address;
    assign o_req_write_data = r_write_data;
    assign o_req_write_mask = r_write_mask;

    rggen_access_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_grant_write || w_grant_read),
        .i_enable (w_in_access),
        .o_expire (w_expire)
    );

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_write) begin
                    w_state_next = StWriteAccess;
                end else if (w_grant_read) begin
                    w_state_next = StReadAccess;
                end
            end
            StWriteAccess:   if (w_access_done) w_state_next = StWriteResponse;
            StReadAccess:    if (w_access_done) w_state_next = StReadResponse;
            StWriteResponse: if (axi.bready)    w_state_next = StIdle;
            StReadResponse:  if (axi.rready)    w_state_next = StIdle;
            default:         w_state_next = StIdle;
        endcase
    end

    // State, request capture, response capture and fairness flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_priority_write <= 1'b1;
            r_write          <= 1'b0;
            r_address        <= '0;
            r_write_data     <= '0;
            r_write_mask     <= '0;
            r_status         <= RESP_OKAY;
            r_read_data      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_write) begin
                r_write      <= 1'b1;
                r_address    <= axi.awaddr & ~LOW_MASK;
                r_write_data <= axi.wdata;
                r_write_mask <= w_mask;
            end else if (w_grant_read) begin
                r_write      <= 1'b0;
                r_address    <= axi.araddr & ~LOW_MASK;
                r_write_data <= '0;
                r_write_mask <= '0;
            end
            // A real response beats a coincident timeout
            if (w_access_done) begin
                r_status    <= i_resp_valid ? i_resp_status : RESP_SLVERR;
                r_read_data <= (i_resp_valid && (i_resp_status == RESP_OKAY)) ?
                               i_resp_read_data : '0;
            end
            if (w_resp_done) begin
                r_priority_write <= ~r_priority_write;
            end
        end
    end
endmodule

// File: tb/tb_rggen_axi4lite_host_bridge.sv
// Randomised scoreboard bench for the AXI4-Lite host bridge (TIMEOUT_CYCLES = 4).
module tb_rggen_axi4lite_host_bridge;
    localparam int TMO = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; logic [31:0] mask; } req_t;
    typedef struct { logic [1:0] resp; logic [31:0] data; } rsp_t;
    typedef struct { int k; logic [1:0] st; logic [31:0] rd; } plan_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_req_valid, o_req_write;
    logic [15:0] o_req_address;
    logic [31:0] o_req_write_data, o_req_write_mask;
    logic        i_resp_valid;
    logic [1:0]  i_resp_status;
    logic [31:0] i_resp_read_data;

    int total = 0;
    int bad   = 0;

    req_t  exp_req[$];
    rsp_t  exp_b[$];
    rsp_t  exp_r[$];
    plan_t plan_q[$];
    bit    pri_wr;

    rggen_axi4lite_host_bridge_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

    rggen_axi4lite_host_bridge #(
        .ADDRESS_WIDTH  (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .axi              (bus),
        .o_req_valid      (o_req_valid),
        .o_req_write      (o_req_write),
        .o_req_address    (o_req_address),
        .o_req_write_data (o_req_write_data),
        .o_req_write_mask (o_req_write_mask),
        .i_resp_valid     (i_resp_valid),
        .i_resp_status    (i_resp_status),
        .i_resp_read_data (i_resp_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic give_up(input string name, input int waited, input int limit);
        total++;
        bad++;
        $display("FAIL %s: waited %0d cycles, required <= %0d", name, waited, limit);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference: every set strobe bit enables its whole byte lane
    function automatic logic [31:0] model_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m |= 32'hFF << (8 * i);
        return m;
    endfunction

    // Register-block responder: answers k cycles into each access as planned
    initial begin
        plan_t p;
        i_resp_valid = 1'b0;
        i_resp_status = '0;
        i_resp_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (o_req_valid && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                for (int c = 1; c < p.k && o_req_valid; c++) begin
                    @(posedge clk); #1;
                end
                if (o_req_valid) begin
                    i_resp_valid = 1'b1;
                    i_resp_status = p.st;
                    i_resp_read_data = p.rd;
                    @(posedge clk); #1;
                    i_resp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: checks each access and each response against the queued expectations
    req_t cur_req;
    rsp_t cur_b, cur_r;
    bit   req_active = 0, b_hold = 0, r_hold = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_active = 0; b_hold = 0; r_hold = 0;
        end else begin
            if (o_req_valid) begin
                if (!req_active) begin
                    if (exp_req.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got access, want none");
                    end else cur_req = exp_req.pop_front();
                    req_active = 1;
                end
                check("req_write", o_req_write, cur_req.wr);
                check("req_address", o_req_address, cur_req.addr);
                check("req_mask", o_req_write_mask, cur_req.mask);
                if (cur_req.wr) check("req_wdata", o_req_write_data, cur_req.data);
                check("ready_in_access", {bus.awready, bus.wready, bus.arready}, 0);
            end else req_active = 0;
            if (bus.bvalid) begin
                if (!b_hold) begin
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_bvalid: got bvalid, want none");
                    end else cur_b = exp_b.pop_front();
                    b_hold = 1;
                end
                check("bresp", bus.bresp, cur_b.resp);
                if (bus.bready) b_hold = 0;
            end
            if (bus.rvalid) begin
                if (!r_hold) begin
                    if (exp_r.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rvalid: got rvalid, want none");
                    end else cur_r = exp_r.pop_front();
                    r_hold = 1;
                end
                check("rresp", bus.rresp, cur_r.resp);
                check("rdata", bus.rdata, cur_r.data);
                if (bus.rready) r_hold = 0;
            end
        end
    end

    // Queue expectations for one access given the responder's plan for it
    task automatic expect_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, input int k, input logic [1:0] rs,
                              input logic [31:0] rd);
        req_t q; rsp_t e; plan_t p;
        q.wr = wr; q.addr = addr & 16'hFFFC; q.data = wd;
        q.mask = wr ? model_mask(st) : 32'h0;
        exp_req.push_back(q);
        p.k = k; p.st = rs; p.rd = rd;
        plan_q.push_back(p);
        if (k <= TMO) begin e.resp = rs; e.data = (rs == OKAY) ? rd : 32'h0; end
        else begin e.resp = SLVERR; e.data = 32'h0; end
        if (wr) exp_b.push_back(e); else exp_r.push_back(e);
        pri_wr = !pri_wr;
    endtask

    // One isolated transaction; called at posedge+1 with the bridge idle
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int k, input logic [1:0] rs,
                           input logic [31:0] rd, input int dly, input bit hold_ar);
        int lat;
        expect_txn(wr, addr, wd, st, k, rs, rd);
        if (wr) begin
            bus.awvalid = 1; bus.awaddr = addr; bus.wvalid = 1; bus.wdata = wd; bus.wstrb = st;
        end else begin
            bus.arvalid = 1; bus.araddr = addr;
        end
        lat = 0;
        @(negedge clk);
        while (!(wr ? (bus.awready && bus.wready) : bus.arready)) begin
            lat++;
            if (lat > 20) give_up("accept_wait", lat, 20);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        lat = 1;
        @(negedge clk);
        while (!(wr ? bus.bvalid : bus.rvalid)) begin
            lat++;
            if (lat > 30) give_up("resp_wait", lat, 30);
            @(negedge clk);
        end
        check("resp_latency", lat, ((k <= TMO) ? k : TMO) + 1);
        repeat (dly) begin
            @(posedge clk); #1;
            if (hold_ar) begin bus.arvalid = 1; bus.araddr = 16'h0100; end
            @(negedge clk);
            if (hold_ar) check("arready_blocked", bus.arready, 0);
        end
        @(posedge clk); #1;
        bus.arvalid = 0;
        if (wr) bus.bready = 1; else bus.rready = 1;
        @(posedge clk); #1;
        bus.bready = 0; bus.rready = 0;
    endtask

    initial begin
        int cnt, cyc;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        rst_n = 0;
        pri_wr = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", o_req_valid, 0);
        check("rst_req_fields", {o_req_write, o_req_address, o_req_write_data, o_req_write_mask}, 0);
        check("rst_valids", {bus.bvalid, bus.rvalid}, 0);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_resp", {bus.bresp, bus.rresp, bus.rdata}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Directed cases
        run_txn(1, 16'h0010, 32'hA5A5_5A5A, 4'b0101, 2, OKAY, 32'h0, 0, 0);
        run_txn(0, 16'h0013, 32'h0, 4'h0, 1, OKAY, 32'h1234_5678, 0, 0);
        run_txn(0, 16'h0020, 32'h0, 4'h0, 9, OKAY, 32'hDEAD_BEEF, 0, 0);
        run_txn(0, 16'h0024, 32'h0, 4'h0, 4, OKAY, 32'hCAFE_F00D, 0, 0);
        run_txn(0, 16'h0028, 32'h0, 4'h0, 3, SLVERR, 32'h5555_AAAA, 0, 0);
        run_txn(1, 16'h0030, 32'h0BAD_F00D, 4'b1001, 1, SLVERR, 32'h0, 10, 1);

        // Randomised isolated transactions
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(1, 6)), $urandom_range(0, 1) ? SLVERR : OKAY,
                    $urandom, int'($urandom_range(0, 2)), 0);
        end

        // Reset in the middle of a read access
        exp_req.push_back('{wr: 0, addr: 16'h0040, data: 32'h0, mask: 32'h0});
        bus.arvalid = 1; bus.araddr = 16'h0042;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("midrst_req_valid", o_req_valid, 0);
        check("midrst_rvalid", bus.rvalid, 0);
        check("midrst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        pri_wr = 1;
        @(negedge clk);
        check("postrst_idle_arready", bus.arready, 1);
        check("postrst_req_valid", o_req_valid, 0);
        bus.arvalid = 0;
        @(posedge clk); #1;

        // Both directions requesting every cycle: grants must alternate from write
        for (int n = 0; n < 6; n++) begin
            expect_txn(pri_wr, pri_wr ? 16'h0050 : 16'h0054, 32'h1357_9BDF, 4'hF,
                       int'($urandom_range(1, 3)), OKAY, $urandom);
        end
        bus.awvalid = 1; bus.awaddr = 16'h0050; bus.wvalid = 1;
        bus.wdata = 32'h1357_9BDF; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddr = 16'h0054;
        bus.bready = 1; bus.rready = 1;
        cnt = 0; cyc = 0;
        while (cnt < 6) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) give_up("arb_wait", cyc, 200);
            if ((bus.bvalid && bus.bready) || (bus.rvalid && bus.rready)) cnt++;
        end
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
        repeat (4) @(posedge clk);
        #1;
        check("leftover", exp_req.size() + exp_b.size() + exp_r.size() + plan_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
